// File: rtl/select_parents_pkg.sv
// Shared constants and types for the parent-selection stage.
//   NUM_IND / CHROM_W / DIST_W / IDX_W : population geometry
//   DIST_SENTINEL : tracker start value, one bit wider than any distance, so it
//                   is larger than every real distance (including all-ones)
//   state_t       : FSM encoding (IDLE=0, SCAN=1, FINISH=2)
//   track_t       : running best / second-best values and their indices
package select_parents_pkg;

  localparam int NUM_IND = 50;
  localparam int CHROM_W = 150;
  localparam int DIST_W  = 12;
  localparam int IDX_W   = 6;

  localparam logic [DIST_W:0] DIST_SENTINEL = {1'b1, {DIST_W{1'b0}}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    FINISH = 2'd2
  } state_t;

  typedef struct packed {
    logic [DIST_W:0]    best_d;
    logic [DIST_W:0]    second_d;
    logic [IDX_W-1:0]   best_i;
    logic [IDX_W-1:0]   second_i;
  } track_t;

endpackage

// File: rtl/select_parents_top2_tracker.sv
// Combinational two-smallest tracker step.
//   cur : current best / second values and indices
//   d   : incoming distance
//   i   : index of the incoming distance
//   nxt : updated best / second
// Comparisons are strict, so on a tie the earlier (lower) index keeps its
// place; equal duplicates therefore fill best and second in index order.
module top2_tracker
  import select_parents_pkg::*;
(
  input  track_t            cur,
  input  logic [DIST_W-1:0] d,
  input  logic [IDX_W-1:0]  i,
  output track_t            nxt
);

  logic [DIST_W:0] d_ext;

  assign d_ext = {1'b0, d};

  always_comb begin
    nxt = cur;
    if (d_ext < cur.best_d) begin
      // Old best slides down to second.
      nxt.second_d = cur.best_d;
      nxt.second_i = cur.best_i;
      nxt.best_d   = d_ext;
      nxt.best_i   = i;
    end else if (d_ext < cur.second_d) begin
      nxt.second_d = d_ext;
      nxt.second_i = i;
    end
  end

endmodule

// File: rtl/select_parents.sv
// Parent selection: after a start pulse, latches all route distances, scans
// them one per cycle to find the shortest and second-shortest tours, then
// registers their indices, distances and chromosomes.
//   clk, rst      : clock, synchronous active-high reset
//   start         : single-cycle request, ignored while busy
//   pop           : population, individual i at pop[i*CHROM_W +: CHROM_W]
//   distances     : distance of individual i at [i*DIST_W +: DIST_W]
//   busy          : scan in progress (SCAN or FINISH)
//   done          : results valid; held until the next accepted start
//   best_idx/dist, second_idx/dist : the two smallest distances
//   parent_a/b    : chromosomes at best_idx / second_idx
// Timing: start accepted at edge T -> done high after edge T+NUM_IND+1.
module select_parents
  import select_parents_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [NUM_IND*CHROM_W-1:0]  pop,
  input  logic [NUM_IND*DIST_W-1:0]   distances,
  output logic                        busy,
  output logic                        done,
  output logic [IDX_W-1:0]            best_idx,
  output logic [IDX_W-1:0]            second_idx,
  output logic [DIST_W-1:0]           best_dist,
  output logic [DIST_W-1:0]           second_dist,
  output logic [CHROM_W-1:0]          parent_a,
  output logic [CHROM_W-1:0]          parent_b
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_IND - 1);
  localparam track_t TRACK_INIT = '{
    best_d:   DIST_SENTINEL,
    second_d: DIST_SENTINEL,
    best_i:   '0,
    second_i: '0
  };

  state_t                      state;
  state_t                      state_nxt;
  logic [IDX_W-1:0]            cnt;
  logic [NUM_IND*DIST_W-1:0]   dist_q;
  track_t                      trk;
  track_t                      trk_nxt;
  logic [DIST_W-1:0]           d_cur;

  assign d_cur = dist_q[cnt*DIST_W +: DIST_W];
  assign busy  = (state != IDLE);

  top2_tracker u_tracker (
    .cur (trk),
    .d   (d_cur),
    .i   (cnt),
    .nxt (trk_nxt)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SCAN;
      SCAN:    if (cnt == LAST_IDX) state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      dist_q      <= '0;
      trk         <= TRACK_INIT;
      done        <= 1'b0;
      best_idx    <= '0;
      second_idx  <= '0;
      best_dist   <= '0;
      second_dist <= '0;
      parent_a    <= '0;
      parent_b    <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            dist_q <= distances;
            cnt    <= '0;
            trk    <= TRACK_INIT;
            // Previous results stay visible; only the valid flag drops.
            done   <= 1'b0;
          end
        end
        SCAN: begin
          trk <= trk_nxt;
          cnt <= cnt + 1'b1;
        end
        FINISH: begin
          best_idx    <= trk.best_i;
          second_idx  <= trk.second_i;
          // With at least two individuals the sentinel has been displaced,
          // so the dropped top bit is always zero here.
          best_dist   <= trk.best_d[DIST_W-1:0];
          second_dist <= trk.second_d[DIST_W-1:0];
          parent_a    <= pop[trk.best_i*CHROM_W +: CHROM_W];
          parent_b    <= pop[trk.second_i*CHROM_W +: CHROM_W];
          done        <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_select_parents.sv
module tb_select_parents;

  localparam int N  = 50;
  localparam int CW = 150;
  localparam int DW = 12;
  localparam int IW = 6;
  localparam int LAT = 51;

  typedef struct {
    logic [IW-1:0] bi;
    logic [IW-1:0] si;
    logic [DW-1:0] bd;
    logic [DW-1:0] sd;
    logic [CW-1:0] pa;
    logic [CW-1:0] pb;
    bit            chk_par;
    int            due;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [N*CW-1:0]   pop = '0;
  logic [N*DW-1:0]   distances = '0;
  logic              busy;
  logic              done;
  logic [IW-1:0]     best_idx;
  logic [IW-1:0]     second_idx;
  logic [DW-1:0]     best_dist;
  logic [DW-1:0]     second_dist;
  logic [CW-1:0]     parent_a;
  logic [CW-1:0]     parent_b;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  exp_t exp_q[$];
  exp_t last_exp;

  select_parents dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .pop         (pop),
    .distances   (distances),
    .busy        (busy),
    .done        (done),
    .best_idx    (best_idx),
    .second_idx  (second_idx),
    .best_dist   (best_dist),
    .second_dist (second_dist),
    .parent_a    (parent_a),
    .parent_b    (parent_b)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Best = smallest value, lowest index on ties; second = smallest of the
  // rest, lowest index on ties.
  function automatic exp_t model(input logic [N*DW-1:0] d, input logic [N*CW-1:0] p);
    exp_t e;
    int b;
    int s;
    b = 0;
    for (int i = 1; i < N; i++)
      if (d[i*DW +: DW] < d[b*DW +: DW]) b = i;
    s = (b == 0) ? 1 : 0;
    for (int i = 0; i < N; i++)
      if (i != b && d[i*DW +: DW] < d[s*DW +: DW]) s = i;
    e.bi = IW'(b);
    e.si = IW'(s);
    e.bd = d[b*DW +: DW];
    e.sd = d[s*DW +: DW];
    e.pa = p[b*CW +: CW];
    e.pb = p[s*CW +: CW];
    e.chk_par = 1'b1;
    e.due = 0;
    return e;
  endfunction

  function automatic logic [N*CW-1:0] rand_pop();
    logic [N*CW-1:0] p;
    for (int k = 0; k < N*CW; k++) p[k] = 1'($urandom_range(0, 1));
    return p;
  endfunction

  // ---------------- drivers ----------------
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Issues start; optionally pushes the expected result due LAT edges later.
  task automatic start_run(input logic [N*DW-1:0] d, input logic [N*CW-1:0] p,
                           input bit push, input bit chk_par);
    exp_t e;
    @(negedge clk);
    distances = d;
    pop       = p;
    start     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    if (push) begin
      e = model(d, p);
      e.chk_par = chk_par;
      e.due = cyc + LAT;
      exp_q.push_back(e);
      last_exp = e;
    end
  endtask

  task automatic wait_results(input int limit);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL timeout: %0d results still pending after %0d cycles", exp_q.size(), limit);
      exp_q.delete();
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic done_d = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst && done && !done_d) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: got done=1 expected no result at cycle %0d", cyc);
      end else begin
        e = exp_q.pop_front();
        chk("latency", CW'(cyc), CW'(e.due));
        chk("best_idx", CW'(best_idx), CW'(e.bi));
        chk("second_idx", CW'(second_idx), CW'(e.si));
        chk("best_dist", CW'(best_dist), CW'(e.bd));
        chk("second_dist", CW'(second_dist), CW'(e.sd));
        if (e.chk_par) begin
          chk("parent_a", parent_a, e.pa);
          chk("parent_b", parent_b, e.pb);
        end
      end
    end
    done_d = done;
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [N*DW-1:0] d;
    logic [N*DW-1:0] d2;
    logic [N*CW-1:0] p;
    logic [IW-1:0]   prev_bi;

    do_reset();
    @(negedge clk);
    chk("rst_busy", CW'(busy), '0);
    chk("rst_done", CW'(done), '0);
    chk("rst_best_idx", CW'(best_idx), '0);
    chk("rst_best_dist", CW'(best_dist), '0);
    chk("rst_parent_a", parent_a, '0);

    // Distinct descending distances.
    for (int i = 0; i < N; i++) d[i*DW +: DW] = DW'(1000 - i*10);
    start_run(d, rand_pop(), 1, 1);
    wait_results(200);

    // Ties at 100 (idx 3 and 7) among 300s.
    for (int i = 0; i < N; i++) d[i*DW +: DW] = DW'(300);
    d[3*DW +: DW] = DW'(100);
    d[7*DW +: DW] = DW'(100);
    start_run(d, rand_pop(), 1, 1);
    wait_results(200);

    // All at the maximum value.
    for (int i = 0; i < N; i++) d[i*DW +: DW] = '1;
    start_run(d, rand_pop(), 1, 1);
    wait_results(200);

    // Best at index 0, second at the last index.
    for (int i = 0; i < N; i++) d[i*DW +: DW] = DW'(4000);
    d[0*DW +: DW] = DW'(1);
    d[49*DW +: DW] = DW'(2);
    start_run(d, rand_pop(), 1, 1);
    wait_results(200);

    // Changing pop after done must not disturb the registered parents.
    @(negedge clk);
    pop = rand_pop();
    repeat (3) @(negedge clk);
    chk("hold_parent_a", parent_a, last_exp.pa);
    chk("hold_parent_b", parent_b, last_exp.pb);

    // Inputs change during the scan: results follow the captured distances.
    for (int i = 0; i < N; i++) d[i*DW +: DW] = DW'($urandom_range(0, 4095));
    start_run(d, rand_pop(), 1, 0);
    repeat (5) @(negedge clk);
    distances = '0;
    pop = rand_pop();
    wait_results(200);

    // Reset at cycle 20 of a scan aborts it with no result.
    for (int i = 0; i < N; i++) d[i*DW +: DW] = DW'($urandom_range(0, 4095));
    start_run(d, rand_pop(), 0, 0);
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", CW'(busy), '0);
    chk("midrst_done", CW'(done), '0);
    chk("midrst_best_dist", CW'(best_dist), '0);
    chk("midrst_second_idx", CW'(second_idx), '0);
    chk("midrst_parent_b", parent_b, '0);
    repeat (60) @(negedge clk);
    start_run(d, rand_pop(), 1, 1);
    wait_results(200);

    // Start while busy is ignored (different distances presented with it).
    for (int i = 0; i < N; i++) d[i*DW +: DW] = DW'($urandom_range(100, 4095));
    p = rand_pop();
    start_run(d, p, 1, 1);
    repeat (9) @(negedge clk);
    for (int i = 0; i < N; i++) d2[i*DW +: DW] = DW'(50);
    distances = d2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_during_scan", CW'(busy), CW'(1));
    wait_results(200);

    // Back-to-back: start while done=1 is accepted; done drops, old outputs hold.
    prev_bi = last_exp.bi;
    for (int i = 0; i < N; i++) d[i*DW +: DW] = DW'(500);
    d[5*DW +: DW] = DW'(1);
    d[40*DW +: DW] = DW'(2);
    start_run(d, rand_pop(), 1, 1);
    chk("b2b_done_drop", CW'(done), '0);
    chk("b2b_hold_best_idx", CW'(best_idx), CW'(prev_bi));
    chk("b2b_busy", CW'(busy), CW'(1));
    wait_results(200);

    // start and rst together: reset wins.
    @(negedge clk);
    start = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    start = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_start_busy", CW'(busy), '0);
    chk("rst_start_done", CW'(done), '0);

    // Randomized runs; narrow ranges force many ties.
    for (int r = 0; r < 10; r++) begin
      int hi;
      hi = (r % 2 == 0) ? 7 : 4095;
      for (int i = 0; i < N; i++) d[i*DW +: DW] = DW'($urandom_range(0, hi));
      start_run(d, rand_pop(), 1, 1);
      wait_results(200);
    end

    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/select_parents.md
Name: select_parents

Overview:
- Downstream consumer of the population distance stage. Once all 50 route distances are valid, it scans them sequentially, one per cycle.
- Finds the shortest and second-shortest tours.
- Presents their indices, distances and 150-bit chromosomes as the parent pair for the crossover/mutation stage.

Parameters:
- NUM_IND, 50: individuals in the population.
- CHROM_W, 150: bits per chromosome.
- DIST_W, 12: bits per distance.
- IDX_W, 6: index width, equal to clog2(NUM_IND).

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  single-cycle pulse; sampled only when not busy.
- pop  input  NUM_IND*CHROM_W  population; individual i is at pop[i*CHROM_W +: CHROM_W]. Upstream holds it stable from start until done.
- distances  input  NUM_IND*DIST_W  distance of individual i at [i*DIST_W +: DIST_W]. Captured at start.
- busy  output  1  high while scanning.
- done  output  1  level; high from result-valid until the next accepted start.
- best_idx  output  IDX_W  index of the shortest distance.
- second_idx  output  IDX_W  index of the second-shortest distance.
- best_dist  output  DIST_W  shortest distance.
- second_dist  output  DIST_W  second-shortest distance.
- parent_a  output  CHROM_W  chromosome at best_idx.
- parent_b  output  CHROM_W  chromosome at second_idx.

Behaviour:
- Reset: state IDLE, busy=0, done=0, and every result output 0. Reset mid-scan aborts the scan with no done pulse.
- States:
  - IDLE: start -> SCAN; the distances vector is latched, cnt=0, and the tracker is initialised.
  - SCAN: one element per cycle, cnt 0..NUM_IND-1; after cnt==NUM_IND-1 -> FINISH.
  - FINISH: one cycle; registers the outputs, selects the parents from pop, sets done=1 -> IDLE.
- Latency: start accepted at edge T; done=1 and outputs valid after edge T+NUM_IND+1 (51 cycles).
- busy=1 from edge T through the FINISH edge.
- Tracker initialisation: best and second hold the sentinel {1'b1, zeros}, DIST_W+1 bits wide. Any real distance, including all-ones 4095, is therefore smaller.
- Per element d at index i, all comparisons strict:
  - If d < best: second <= best, best <= d, with the indices shifted the same way.
  - Else if d < second: second <= d.
  - Else no change.
- Ties: the lower index wins best. Equal duplicates fill best and second in index order.
- Output distances are the low DIST_W bits of the tracker. With NUM_IND >= 2 the sentinel never survives.
- start while busy is ignored.
- start while done=1 is accepted: done drops on the next edge, and the previous outputs hold until FINISH overwrites them.
- start and rst in the same cycle: rst wins.
- parent_a and parent_b are registered in FINISH using a variable part-select on pop. Changing pop after done has no effect on the outputs.

Decomposition:
- Shared package constants: NUM_IND, CHROM_W, DIST_W, IDX_W, DIST_SENTINEL, and the state encoding (IDLE=0, SCAN=1, FINISH=2).
- One natural sub-module: top2_tracker. It is purely combinational, taking the current best/second values and indices plus the incoming d/i, and producing the next best/second.
- The FSM, counter, latches and chromosome mux stay in select_parents.

Test Plan:
- Distinct distances: distances[i]=1000-i*10, so individual 49 has 510 and individual 48 has 520. Pulse start -> after 51 cycles done=1, best_idx=49, best_dist=510, second_idx=48, second_dist=520, parent_a=pop slice 49, parent_b=pop slice 48.
- Ties: all distances 300 except idx7=idx3=100 -> best_idx=3, second_idx=7, both dists 100. All distances 4095 -> best_idx=0, second_idx=1, dists 4095.
- Input change during scan: after start, change distances to all 0 and change pop -> results reflect the captured distances. pop must be held stable while busy, so the parents are checked only with pop held.
- Reset mid-scan: assert rst at cycle 20 of the scan -> busy=0, done=0, outputs 0. A new start -> correct result 51 cycles later.
- Back-to-back runs: a second start while busy (cycle 10) is ignored. A start one cycle after done -> done falls next edge, rises again 51 cycles later with the new minima (idx 5 = 1, idx 40 = 2).
- Best at index 0 and second at the last index: distances[0]=1, distances[49]=2, others 4000 -> best_idx=0, second_idx=49.
